// File: rtl/acc_core_mc_pkg.sv
// Shared definitions for the multi-cycle accumulator core: opcodes, FSM states
// and the 9-bit instruction field layout.
package acc_core_mc_pkg;

  typedef enum logic [3:0] {
    kLDR, kSTR, kLDI, kMLD, kMST, kADD, kADC, kSUB,
    kAND, kXOR, kSHL, kSHR, kBRZ, kBRN, kJMP
  } opcode_e;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_e;

  localparam int unsigned INSTR_W  = 9;
  localparam int unsigned OP_MSB   = 8;
  localparam int unsigned OP_LSB   = 5;
  localparam int unsigned OPND_MSB = 4;
  localparam int unsigned OPND_LSB = 0;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU for the accumulator core; carry passes through unchanged
// for operations that do not define it.
module acc_alu
  import acc_core_mc_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] r,
  input  logic          c,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] w_sum;

  always_comb begin
    w_sum  = '0;
    result = acc;
    carry  = c;
    case (op)
      kADD: begin
        w_sum  = {1'b0, acc} + {1'b0, r};
        result = w_sum[DW-1:0];
        carry  = w_sum[DW];
      end
      kADC: begin
        w_sum  = {1'b0, acc} + {1'b0, r} + {{DW{1'b0}}, c};
        result = w_sum[DW-1:0];
        carry  = w_sum[DW];
      end
      kSUB: begin
        // Top bit of the widened difference is the borrow.
        w_sum  = {1'b0, acc} - {1'b0, r};
        result = w_sum[DW-1:0];
        carry  = w_sum[DW];
      end
      kAND: result = acc & r;
      kXOR: result = acc ^ r;
      kSHL: begin
        result = {acc[DW-2:0], 1'b0};
        carry  = acc[DW-1];
      end
      kSHR: begin
        result = {1'b0, acc[DW-1:1]};
        carry  = acc[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_core_mc.sv
// Multi-cycle accumulator core: start/done run control, synchronous instruction
// fetch and a req/ack data-memory port tolerant of variable latency.
module acc_core_mc
  import acc_core_mc_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned PW   = 16,
  parameter int unsigned NREG = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dm_req,
  output logic               dm_we,
  output logic [DW-1:0]      dm_addr,
  output logic [DW-1:0]      dm_wdata,
  input  logic [DW-1:0]      dm_rdata,
  input  logic               dm_ack,
  output logic               done,
  output logic [DW-1:0]      acc_out
);

  localparam int unsigned RIW = (NREG > 1) ? $clog2(NREG) : 1;

  state_e          r_state;
  logic [PW-1:0]   r_pc;
  logic [DW-1:0]   r_acc;
  logic            r_z, r_n, r_c;
  logic [DW-1:0]   r_regs [NREG];
  logic            r_dm_req, r_dm_we, r_done;
  logic [DW-1:0]   r_dm_addr, r_dm_wdata;

  logic [3:0]      w_opc;
  logic [4:0]      w_opnd;
  logic [RIW-1:0]  w_ridx;
  logic [DW-1:0]   w_r, w_alu_res, w_acc_nx;
  logic            w_alu_c;
  logic [PW-1:0]   w_pc_inc, w_pc_br;
  logic            w_acc_we, w_c_we, w_reg_we, w_mem, w_halt, w_take;

  assign w_opc    = imem_data[OP_MSB:OP_LSB];
  assign w_opnd   = imem_data[OPND_MSB:OPND_LSB];
  assign w_ridx   = RIW'({1'b0, w_opnd[3:0]} % 5'(NREG));
  assign w_r      = r_regs[w_ridx];
  assign w_pc_inc = r_pc + PW'(1);
  assign w_pc_br  = r_pc + {{(PW-5){w_opnd[4]}}, w_opnd};

  acc_alu #(.DW(DW)) u_alu (
    .op     (w_opc),
    .acc    (r_acc),
    .r      (w_r),
    .c      (r_c),
    .result (w_alu_res),
    .carry  (w_alu_c)
  );

  always_comb begin
    w_acc_we = 1'b0;
    w_c_we   = 1'b0;
    w_reg_we = 1'b0;
    w_mem    = 1'b0;
    w_halt   = 1'b0;
    w_take   = 1'b0;
    w_acc_nx = w_alu_res;
    case (w_opc)
      kLDR: begin w_acc_we = 1'b1; w_acc_nx = w_r; end
      kSTR: w_reg_we = 1'b1;
      kLDI: begin w_acc_we = 1'b1; w_acc_nx = DW'(w_opnd); end
      kMLD, kMST: w_mem = 1'b1;
      kADD, kADC, kSUB, kSHL, kSHR: begin w_acc_we = 1'b1; w_c_we = 1'b1; end
      kAND, kXOR: w_acc_we = 1'b1;
      kBRZ: w_take = r_z;
      kBRN: w_take = r_n;
      kJMP: begin
        w_halt = (w_opnd == 5'd0);
        w_take = (w_opnd != 5'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_acc      <= '0;
      r_z        <= 1'b0;
      r_n        <= 1'b0;
      r_c        <= 1'b0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_done     <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (start) begin
          r_pc    <= '0;
          r_state <= FETCH;
        end
        FETCH: r_state <= EXEC;
        EXEC: begin
          if (w_halt) begin
            r_state <= HALT;
            r_done  <= 1'b1;
          end else if (w_mem) begin
            r_state    <= MEM;
            r_dm_req   <= 1'b1;
            r_dm_we    <= (w_opc == kMST);
            r_dm_addr  <= w_r;
            r_dm_wdata <= r_acc;
          end else begin
            r_state <= FETCH;
            r_pc    <= w_take ? w_pc_br : w_pc_inc;
            if (w_acc_we) begin
              r_acc <= w_acc_nx;
              r_z   <= (w_acc_nx == '0);
              r_n   <= w_acc_nx[DW-1];
            end
            if (w_c_we) r_c <= w_alu_c;
            if (w_reg_we) r_regs[w_ridx] <= r_acc;
          end
        end
        MEM: if (dm_ack) begin
          r_dm_req <= 1'b0;
          r_dm_we  <= 1'b0;
          r_pc     <= w_pc_inc;
          r_state  <= FETCH;
          if (!r_dm_we) begin
            r_acc <= dm_rdata;
            r_z   <= (dm_rdata == '0);
            r_n   <= dm_rdata[DW-1];
          end
        end
        HALT: if (start) begin
          r_pc    <= '0;
          r_done  <= 1'b0;
          r_state <= FETCH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign dm_req    = r_dm_req;
  assign dm_we     = r_dm_we;
  assign dm_addr   = r_dm_addr;
  assign dm_wdata  = r_dm_wdata;
  assign done      = r_done;
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_acc_core_mc.sv
// Bench for acc_core_mc: an instruction-level model of the ISA checked against
// the core every cycle, plus hand-computed end results for each program.
module tb_acc_core_mc;

  localparam int LDR = 0, STR = 1, LDI = 2, MLD = 3, MST = 4, ADD = 5, ADC = 6, SUB = 7;
  localparam int AND = 8, XOR = 9, SHL = 10, SHR = 11, BRZ = 12, BRN = 13, JMP = 14, UND = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [15:0] imem_addr;
  logic [8:0]  imem_data;
  logic        dm_req, dm_we, dm_ack, done;
  logic [7:0]  dm_addr, dm_wdata, dm_rdata, acc_out;

  logic        start2, dm_req2, dm_we2, done2;
  logic [15:0] imem_addr2, dm_addr2, dm_wdata2, acc_out2;
  logic [8:0]  imem_data2;

  acc_core_mc #(.DW(8), .PW(16), .NREG(16)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .done(done), .acc_out(acc_out)
  );

  acc_core_mc #(.DW(16), .PW(16), .NREG(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .dm_req(dm_req2), .dm_we(dm_we2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2),
    .dm_rdata(16'h0000), .dm_ack(dm_req2), .done(done2), .acc_out(acc_out2)
  );

  logic [8:0] prog  [65536];
  logic [8:0] prog2 [64];
  logic [7:0] xmem  [256];
  int k_st = 1, k_ld = 1, req_cnt, cyc = 0, t_start;
  int checks = 0, errors = 0;

  always @(posedge clk) begin
    imem_data  <= prog[imem_addr];
    imem_data2 <= prog2[imem_addr2[5:0]];
    cyc        <= cyc + 1;
  end

  // Memory acks on the k-th cycle of a request (k = 1 means same-cycle ack).
  assign dm_ack   = dm_req && (req_cnt == ((dm_we ? k_st : k_ld) - 1));
  assign dm_rdata = xmem[dm_addr];
  always @(posedge clk or negedge reset)
    if (!reset) req_cnt <= 0;
    else if (dm_req && !dm_ack) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  always @(posedge clk) if (dm_req && dm_ack && dm_we) xmem[dm_addr] <= dm_wdata;

  // ISA-level model state
  logic [15:0] m_pc;
  logic [7:0]  m_acc;
  logic        m_z, m_n, m_c;
  logic [7:0]  m_reg [16];
  logic [7:0]  m_dmem [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ins(input int op, input int opnd);
    return {op[3:0], opnd[4:0]};
  endfunction

  task automatic set_acc(input logic [7:0] v);
    m_acc = v;
    m_z   = (v == 8'h00);
    m_n   = v[7];
  endtask

  task automatic model_core_reset();
    m_pc = 16'h0; m_acc = 8'h0; m_z = 0; m_n = 0; m_c = 0;
    for (int i = 0; i < 16; i++) m_reg[i] = 8'h0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 65536; i++) prog[i] = ins(JMP, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start   = 1'b1;
    t_start = cyc;
    m_pc    = 16'h0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge of the first fetch cycle; returns in the first HALT cycle.
  task automatic run_prog(input int poke_idx, input int budget);
    int n = 0;
    bit fin = 0;
    while (!fin) begin
      logic [8:0] iw;
      int op;
      logic [4:0] opnd;
      logic [7:0] r, tmp;
      int s;
      bit take, halt;
      if (n >= budget) begin
        checks++; errors++;
        $display("FAIL budget: %0d instructions without halt, required halt", n);
        return;
      end
      iw = prog[m_pc];
      op = int'(iw[8:5]);
      opnd = iw[4:0];
      r = m_reg[opnd[3:0]];
      take = 0; halt = 0;
      chk("fetch_pc", imem_addr, m_pc);
      chk("fetch_done", done, 0);
      chk("fetch_req", dm_req, 0);
      chk("fetch_acc", acc_out, m_acc);
      @(negedge clk);
      chk("exec_pc", imem_addr, m_pc);
      chk("exec_acc", acc_out, m_acc);
      if (n == poke_idx) start = 1'b1;
      case (op)
        LDR: set_acc(r);
        STR: m_reg[opnd[3:0]] = m_acc;
        LDI: set_acc({3'b000, opnd});
        MLD, MST: begin
          for (int j = 0; j < ((op == MST) ? k_st : k_ld); j++) begin
            @(negedge clk);
            start = 1'b0;
            chk("mem_req", dm_req, 1);
            chk("mem_we", dm_we, (op == MST));
            chk("mem_addr", dm_addr, r);
            if (op == MST) chk("mem_wdata", dm_wdata, m_acc);
          end
          if (op == MST) m_dmem[r] = m_acc;
          else set_acc(m_dmem[r]);
        end
        ADD: begin s = m_acc + r;       m_c = s[8]; set_acc(s[7:0]); end
        ADC: begin s = m_acc + r + m_c; m_c = s[8]; set_acc(s[7:0]); end
        SUB: begin m_c = (m_acc < r); tmp = m_acc - r; set_acc(tmp); end
        AND: set_acc(m_acc & r);
        XOR: set_acc(m_acc ^ r);
        SHL: begin m_c = m_acc[7]; set_acc({m_acc[6:0], 1'b0}); end
        SHR: begin m_c = m_acc[0]; set_acc({1'b0, m_acc[7:1]}); end
        BRZ: take = m_z;
        BRN: take = m_n;
        JMP: begin halt = (opnd == 0); take = (opnd != 0); end
        default: ;
      endcase
      if (!halt) m_pc = take ? m_pc + {{11{opnd[4]}}, opnd} : m_pc + 16'd1;
      @(negedge clk);
      start = 1'b0;
      if (halt) begin
        chk("halt_done", done, 1);
        chk("halt_pc", imem_addr, m_pc);
        chk("halt_acc", acc_out, m_acc);
        chk("halt_c", dut.r_c, m_c);
        fin = 1;
      end
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    clear_prog();
    for (int i = 0; i < 64; i++) prog2[i] = ins(JMP, 0);
    for (int i = 0; i < 256; i++) begin
      xmem[i]   = 8'(i) ^ 8'h5A;
      m_dmem[i] = 8'(i) ^ 8'h5A;
    end
    model_core_reset();
    #2 reset = 1'b0;
    #2;
    chk("rst_pc", imem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_acc", acc_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 5 + 3, then halt; start edge plus 2 cycles x 5 instructions
    prog[0] = ins(LDI, 5); prog[1] = ins(STR, 1); prog[2] = ins(LDI, 3);
    prog[3] = ins(ADD, 1); prog[4] = ins(JMP, 0);
    pulse_start();
    run_prog(-1, 20);
    chk("p1_acc", acc_out, 8'd8);
    chk("p1_c", dut.r_c, 0);
    chk("p1_latency", cyc - t_start, 11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p1_done_held", done, 1);
    end
    pulse_start();
    run_prog(-1, 20);
    chk("p1_rerun_acc", acc_out, 8'd8);

    // 31 x 9 wraps to 23 with carry; ADC then gives 55
    clear_prog();
    prog[0] = ins(LDI, 31); prog[1] = ins(STR, 2); prog[2] = ins(LDI, 0);
    for (int i = 3; i < 12; i++) prog[i] = ins(ADD, 2);
    pulse_start();
    run_prog(-1, 30);
    chk("p2_acc", acc_out, 8'd23);
    chk("p2_c", dut.r_c, 1);
    prog[12] = ins(ADC, 2);
    model_core_reset();
    pulse_start();
    m_reg[2] = 8'd31; m_acc = 8'd23; m_c = 1; m_z = 0;
    run_prog(-1, 30);
    chk("p2b_acc", acc_out, 8'd55);
    chk("p2b_c", dut.r_c, 0);

    // store with 3-cycle ack, load with same-cycle ack
    clear_prog();
    k_st = 3; k_ld = 1;
    prog[0] = ins(LDI, 16); prog[1] = ins(STR, 2); prog[2] = ins(LDI, 3);
    prog[3] = ins(STR, 5);  prog[4] = ins(LDI, 21);
    prog[5] = ins(SHL, 0);  prog[6] = ins(SHL, 0);  prog[7] = ins(SHL, 0);
    prog[8] = ins(ADD, 5);  prog[9] = ins(MST, 2);  prog[10] = ins(LDI, 0);
    prog[11] = ins(MLD, 2);
    pulse_start();
    run_prog(-1, 30);
    chk("p3_acc", acc_out, 8'hAB);
    chk("p3_xmem", xmem[16], 8'hAB);

    // branches; start pulse during an EXEC cycle must be ignored
    clear_prog();
    prog[0] = ins(LDI, 5); prog[1] = ins(STR, 3); prog[2] = ins(JMP, 3);
    prog[3] = ins(BRN, 4); prog[4] = ins(JMP, 0); prog[5] = ins(SUB, 3);
    prog[6] = ins(BRZ, 29);
    pulse_start();
    run_prog(2, 20);
    chk("p4_halt_pc", imem_addr, 16'h0004);

    // borrow, logic ops, undefined opcode, LDR/ADC
    clear_prog();
    prog[0] = ins(LDI, 3);  prog[1] = ins(STR, 1); prog[2] = ins(LDI, 1);
    prog[3] = ins(SUB, 1);  prog[4] = ins(BRN, 2); prog[6] = ins(XOR, 1);
    prog[7] = ins(SHR, 0);  prog[8] = ins(AND, 1); prog[9] = ins(UND, 7);
    prog[10] = ins(STR, 7); prog[11] = ins(LDR, 7); prog[12] = ins(ADC, 1);
    pulse_start();
    run_prog(-1, 30);
    chk("p5_acc", acc_out, 8'd6);

    // PC wrap: 1 - 7 = 0xFFFA, then +15 wraps to 0x0009
    clear_prog();
    prog[0] = ins(LDI, 0); prog[1] = ins(JMP, 25); prog[16'hFFFA] = ins(BRZ, 15);
    pulse_start();
    run_prog(-1, 10);
    chk("p6_halt_pc", imem_addr, 16'h0009);

    // reset during MEM aborts the store
    clear_prog();
    k_st = 10;
    prog[0] = ins(LDI, 9); prog[1] = ins(STR, 0); prog[2] = ins(MST, 0);
    pulse_start();
    begin
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        if (dm_req) seen = 1;
      end
      chk("p7_req_seen", seen, 1);
    end
    #2 reset = 1'b0;
    #1;
    chk("p7_req_abort", dm_req, 0);
    chk("p7_we_abort", dm_we, 0);
    chk("p7_acc", acc_out, 0);
    chk("p7_done", done, 0);
    chk("p7_pc", imem_addr, 0);
    model_core_reset();
    @(negedge clk);
    reset = 1'b1;
    chk("p7_xmem", xmem[9], 8'h53);
    clear_prog();
    k_st = 1;
    prog[0] = ins(LDI, 4); prog[1] = ins(ADD, 0);
    pulse_start();
    run_prog(-1, 10);
    chk("p7_regs_cleared", acc_out, 8'd4);

    // DW=16, NREG=4: r5 aliases r1; SHL of 0x8001 gives 0x0002 with carry
    prog2[0] = ins(LDI, 9); prog2[1] = ins(STR, 5); prog2[2] = ins(LDI, 1);
    for (int i = 3; i < 18; i++) prog2[i] = ins(SHL, 0);
    prog2[18] = ins(STR, 2); prog2[19] = ins(LDI, 1); prog2[20] = ins(ADD, 2);
    prog2[21] = ins(SHL, 0); prog2[22] = ins(STR, 3); prog2[23] = ins(LDR, 1);
    prog2[24] = ins(ADC, 3);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (done2) seen = 1;
      end
      chk("d2_done", seen, 1);
    end
    chk("d2_acc", acc_out2, 16'h000C);
    chk("d2_c", dut2.r_c, 0);
    chk("d2_pc", imem_addr2, 16'd25);
    chk("d2_no_mem", {dm_we2, dm_addr2, dm_wdata2}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
